// File: rtl/rgb_led_pkg.sv
// rgb_led_pkg: shared constants, RGB field positions and gamma helper for the RGB LED PWM sink
package rgb_led_pkg;
  localparam int RGB_LED_STEPS = 255;
  localparam logic [7:0] RGB_LED_CNT_MAX = 8'd254;
  localparam int R_HI = 23;
  localparam int R_LO = 16;
  localparam int G_HI = 15;
  localparam int G_LO = 8;
  localparam int B_HI = 7;
  localparam int B_LO = 0;
  function automatic logic [7:0] gamma8(input logic [7:0] d);
    logic [15:0] p;
    p = 16'(d) * 16'(d) + 16'd255;
    return p[15:8];
  endfunction
endpackage

// File: rtl/rgb_led_pwm_chan.sv
// rgb_led_pwm_chan: one PWM channel (active duty register, optional gamma at load, compare, pin register)
// Ports: clk, rst (async, active-high), pwm_cnt (shared 0..254 step count),
//        load (take duty_in this clock), duty_in (8-bit raw duty), pin (registered PWM output).
// Gamma correction applies when RGB_LED_GAMMA_EN is defined.
module rgb_led_pwm_chan
  import rgb_led_pkg::*;
#(
  parameter bit OUT_INV = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] pwm_cnt,
  input  logic       load,
  input  logic [7:0] duty_in,
  output logic       pin
);
  logic [7:0] act;
  logic [7:0] duty;
`ifdef RGB_LED_GAMMA_EN
  assign duty = gamma8(duty_in);
`else
  assign duty = duty_in;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      act <= '0;
      pin <= OUT_INV;
    end else begin
      if (load) act <= duty;
      pin <= (pwm_cnt < act) ^ OUT_INV;
    end
endmodule

// File: rtl/rgb_led_pwm_sink.sv
// rgb_led_pwm_sink: Avalon-ST sink taking {R,G,B} duties and driving three glitch-free PWM LED pins
// Ports: csi_MCLK_clk, rsi_MRST_reset (async, active-high), asi_LEDS_data/valid/ready (readyLatency 0),
//        coe_LED_R/G/B (PWM pins), coe_PERIOD_sync (pulse on the final clock of each period).
// Optional build macro: RGB_LED_GAMMA_EN (gamma-corrects duties at load).
module rgb_led_pwm_sink
  import rgb_led_pkg::*;
#(
  parameter int unsigned PRESCALE = 16,
  parameter bit          OUT_INV  = 1'b0
) (
  input  logic        csi_MCLK_clk,
  input  logic        rsi_MRST_reset,
  input  logic [23:0] asi_LEDS_data,
  input  logic        asi_LEDS_valid,
  output logic        asi_LEDS_ready,
  output logic        coe_LED_R,
  output logic        coe_LED_G,
  output logic        coe_LED_B,
  output logic        coe_PERIOD_sync
);
  localparam logic [15:0] PRE_MAX = 16'(PRESCALE - 1);
  logic [15:0] pre_cnt;
  logic [7:0]  pwm_cnt;
  logic [23:0] pend_rgb;
  logic        pend_full;
  logic        step, pe, acc, load;
  assign step           = pre_cnt == PRE_MAX;
  assign pe             = step && (pwm_cnt == RGB_LED_CNT_MAX);
  assign asi_LEDS_ready = !pend_full;
  assign acc            = asi_LEDS_valid && asi_LEDS_ready;
  assign load           = pe && pend_full;
  // A word accepted on the pe clock only fills the buffer; it waits for the following pe.
  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset)
    if (rsi_MRST_reset) begin
      pre_cnt         <= '0;
      pwm_cnt         <= '0;
      pend_rgb        <= '0;
      pend_full       <= 1'b0;
      coe_PERIOD_sync <= 1'b0;
    end else begin
      pre_cnt         <= step ? '0 : pre_cnt + 16'd1;
      if (step) pwm_cnt <= pe ? '0 : pwm_cnt + 8'd1;
      if (acc) pend_rgb <= asi_LEDS_data;
      pend_full       <= acc || (pend_full && !pe);
      coe_PERIOD_sync <= pe;
    end
  rgb_led_pwm_chan #(.OUT_INV(OUT_INV)) u_r (
    .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .pwm_cnt(pwm_cnt), .load(load),
    .duty_in(pend_rgb[R_HI:R_LO]), .pin(coe_LED_R)
  );
  rgb_led_pwm_chan #(.OUT_INV(OUT_INV)) u_g (
    .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .pwm_cnt(pwm_cnt), .load(load),
    .duty_in(pend_rgb[G_HI:G_LO]), .pin(coe_LED_G)
  );
  rgb_led_pwm_chan #(.OUT_INV(OUT_INV)) u_b (
    .clk(csi_MCLK_clk), .rst(rsi_MRST_reset), .pwm_cnt(pwm_cnt), .load(load),
    .duty_in(pend_rgb[B_HI:B_LO]), .pin(coe_LED_B)
  );
endmodule

// File: tb/tb_rgb_led_pwm_sink.sv
// tb_rgb_led_pwm_sink: random and directed checks of two sink instances against a time-based reference model
module tb_rgb_led_pwm_sink;
  localparam int P0 = 1;
  localparam int P1 = 2;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [23:0] d[2];
  logic [1:0]  v, rdy, r, g, b, sy;
  int          pp[2] = '{P0, P1};
  bit          inv[2] = '{1'b0, 1'b1};
  int          n[2];
  bit          pf[2];
  logic [23:0] pend[2], act[2];
  int          errs = 0, checks = 0;
  int          cr, cg, cb, syncs0;
  always #5 clk = ~clk;
  rgb_led_pwm_sink #(.PRESCALE(P0), .OUT_INV(1'b0)) dut0 (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .asi_LEDS_data(d[0]), .asi_LEDS_valid(v[0]),
    .asi_LEDS_ready(rdy[0]), .coe_LED_R(r[0]), .coe_LED_G(g[0]), .coe_LED_B(b[0]),
    .coe_PERIOD_sync(sy[0])
  );
  rgb_led_pwm_sink #(.PRESCALE(P1), .OUT_INV(1'b1)) dut1 (
    .csi_MCLK_clk(clk), .rsi_MRST_reset(rst), .asi_LEDS_data(d[1]), .asi_LEDS_valid(v[1]),
    .asi_LEDS_ready(rdy[1]), .coe_LED_R(r[1]), .coe_LED_G(g[1]), .coe_LED_B(b[1]),
    .coe_PERIOD_sync(sy[1])
  );
  function automatic logic [7:0] gam(input logic [7:0] x);
`ifdef RGB_LED_GAMMA_EN
    return 8'((int'(x) * int'(x) + 255) / 256);
`else
    return x;
`endif
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      n[k] = 0;
      pf[k] = 1'b0;
      pend[k] = '0;
      act[k] = '0;
    end
  endtask
  // One clock: predict from time since reset, then compare pins/sync after the edge.
  task automatic tick();
    bit pe_[2], acc[2];
    logic [2:0] ep[2];
    int pw;
    for (int k = 0; k < 2; k++) begin
      pw = (n[k] / pp[k]) % 255;
      pe_[k] = (n[k] % (255 * pp[k])) == 255 * pp[k] - 1;
      chk($sformatf("ready%0d", k), rdy[k], !pf[k]);
      acc[k] = v[k] && !pf[k];
      ep[k] = {pw < act[k][23:16], pw < act[k][15:8], pw < act[k][7:0]} ^ {3{inv[k]}};
    end
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("pins%0d", k), {r[k], g[k], b[k]}, ep[k]);
      chk($sformatf("sync%0d", k), sy[k], pe_[k]);
      if (pe_[k] && pf[k]) begin
        act[k] = {gam(pend[k][23:16]), gam(pend[k][15:8]), gam(pend[k][7:0])};
        pf[k] = 1'b0;
      end
      if (acc[k]) begin
        pend[k] = d[k];
        pf[k] = 1'b1;
        v[k] = 1'b0;
      end
      n[k]++;
    end
    cr += int'(r[0]);
    cg += int'(g[0]);
    cb += int'(b[0]);
    syncs0 += int'(sy[0]);
  endtask
  task automatic wait_sync();
    int w = 0;
    while (!sy[0] && w < 1000) begin
      tick();
      w++;
    end
    chk("sync_seen", sy[0], 1'b1);
  endtask
  task automatic count_period(input string tag, input int er, input int eg, input int eb);
    cr = 0;
    cg = 0;
    cb = 0;
    repeat (255 * P0) tick();
    chk({tag, "_r_on"}, cr, er);
    chk({tag, "_g_on"}, cg, eg);
    chk({tag, "_b_on"}, cb, eb);
  endtask
  initial begin
    v = '0;
    d[0] = '0;
    d[1] = '0;
    model_reset();
    #1 rst = 1'b1;
    #10;
    chk("rst_ready", rdy, 2'b11);
    chk("rst_pins0", {r[0], g[0], b[0]}, 3'b000);
    chk("rst_pins1", {r[1], g[1], b[1]}, 3'b111);
    chk("rst_sync", sy, 2'b00);
    #2 rst = 1'b0;
    syncs0 = 0;
    repeat (510) tick();
    chk("idle_sync_count", syncs0, 2);
    d[0] = 24'hFF8000;
    d[1] = 24'hFF8000;
    v = 2'b11;
    tick();
    wait_sync();
    count_period("ff8000", 255, int'(gam(8'h80)), 0);
    d[0] = 24'h010101;
    d[1] = 24'h010101;
    v = 2'b11;
    tick();
    chk("a_accepted", v[0], 1'b0);
    d[0] = 24'h0A0A0A;
    d[1] = 24'h0A0A0A;
    v = 2'b11;
    for (int w = 0; w < 600 && v[0]; w++) tick();
    chk("b_accepted", v[0], 1'b0);
    wait_sync();
    count_period("b_word", int'(gam(8'h0A)), int'(gam(8'h0A)), int'(gam(8'h0A)));
    while (n[0] % 255 != 254) tick();
    d[0] = 24'h505050;
    v[0] = 1'b1;
    tick();
    chk("pe_accept_sync", sy[0], 1'b1);
    count_period("pe_accept_old", int'(gam(8'h0A)), int'(gam(8'h0A)), int'(gam(8'h0A)));
    count_period("pe_accept_new", int'(gam(8'h50)), int'(gam(8'h50)), int'(gam(8'h50)));
    d[0] = 24'h202020;
    d[1] = 24'h202020;
    v = 2'b11;
    tick();
    repeat (60) tick();
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_pins0", {r[0], g[0], b[0]}, 3'b000);
    chk("mid_rst_pins1", {r[1], g[1], b[1]}, 3'b111);
    chk("mid_rst_ready", rdy, 2'b11);
    model_reset();
    v = '0;
    #1 rst = 1'b0;
    cr = 0;
    repeat (600) tick();
    chk("post_rst_dark", cr, 0);
    d[0] = 24'h8001FF;
    d[1] = 24'h8001FF;
    v = 2'b11;
    tick();
    wait_sync();
    count_period("gamma_word", int'(gam(8'h80)), int'(gam(8'h01)), 255);
    repeat (3000) begin
      for (int k = 0; k < 2; k++)
        if (!v[k] && $urandom_range(0, 7) == 0) begin
          v[k] = 1'b1;
          d[k] = 24'($urandom);
        end
      tick();
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
